mem_stage: RTL and testbench
============================

// Module: mem_stage
// PURPOSE
// Memory stage of the 16-bit pipelined CPU. It consumes the EX/MEM pipeline register that execute produces.
// Loads and stores go to data memory over a req/ack handshake. Bus reads from the NN accelerator go over a req/valid handshake.
// It stalls the pipeline while an access is outstanding. It registers MEM/WB results and drives the forwarding inputs of execute.
// PARAMETERS
// ADDR_W      16   data-memory address width; dmem_addr = mem_alu_in[ADDR_W-1:0]
// BUS_TO      255  max cycles waiting for bus_valid before timeout (1..2^TO_W-1)
// TO_W        8    timeout counter width
// PORTS
// clk               in   1       clock
// rst_n             in   1       reset, asynchronous, active-low
// mem_regwrite_in   in   1       EX/MEM: instruction writes register file
// mem_memtoreg_in   in   1       EX/MEM: writeback data from data memory
// mem_bustoreg_in   in   1       EX/MEM: writeback data from accelerator bus
// mem_memread_in    in   1       EX/MEM: load
// mem_memwrite_in   in   1       EX/MEM: store
// mem_alu_in        in   16      EX/MEM: ALU result / address
// mem_wrdata_in     in   16      EX/MEM: store data (forwarded src2)
// mem_regwraddr_in  in   4       EX/MEM: destination register
// dmem_req          out  1       data-memory request
// dmem_we           out  1       1=write, 0=read; valid with dmem_req
// dmem_addr         out  ADDR_W  data-memory address
// dmem_wdata        out  16      store data
// dmem_rdata        in   16      load data, valid when dmem_ack=1
// dmem_ack          in   1       access complete this cycle
// bus_req           out  1       accelerator bus read request
// bus_addr          out  16      bus address (= mem_alu_in)
// bus_rdata         in   16      bus data, valid when bus_valid=1
// bus_valid         in   1       bus read complete this cycle
// mem_stall         out  1       freeze IF/ID/EX and hold the EX/MEM register
// fwd_regwrite      out  1       = mem_regwrite_in (to execute forward unit)
// fwd_memread       out  1       = mem_memread_in | mem_bustoreg_in
// fwd_regwraddr     out  4       = mem_regwraddr_in
// fwd_regwrdata     out  16      = mem_alu_in
// wb_regwrite_out   out  1       MEM/WB: register write enable
// wb_regwraddr_out  out  4       MEM/WB: destination register
// wb_regwrdata_out  out  16      MEM/WB: writeback data
// bus_err           out  1       sticky bus-timeout flag; cleared only by reset
// BEHAVIOUR
// - Reset (async): state=IDLE, timeout count=0, all wb_* outputs=0, bus_err=0. Requests drop immediately.
// - FSM states are IDLE, MEM_WAIT and BUS_WAIT.
// - A memory op is memread|memwrite. It has priority: when set, bustoreg is ignored for this instruction.
// - IDLE with memory op: dmem_req=1 combinationally, with dmem_we=memwrite.
//   - If dmem_ack=1 in the same cycle, the op completes (zero-wait) and there is no stall.
//   - Otherwise the FSM goes to MEM_WAIT.
// - MEM_WAIT: dmem_req held with addr, we and wdata stable. On dmem_ack the op completes and the FSM returns to IDLE.
// - IDLE with bustoreg (no memory op): bus_req=1.
//   - If bus_valid=1, the read completes this cycle.
//   - Otherwise the FSM goes to BUS_WAIT and the count clears to 0.
// - BUS_WAIT: bus_req held and the count increments each cycle.
//   - On bus_valid the read completes with bus_rdata.
//   - If the count reaches BUS_TO with no valid, the read completes with data 16'h0000 and bus_err is set.
//   - The FSM returns to IDLE in either case.
// - mem_stall = pending access and not completing this cycle. It is combinational, so a 0-wait access never stalls.
// - Upstream holds the EX/MEM inputs stable while mem_stall=1.
// - Completion cycle (or non-access instruction) updates MEM/WB at the next clk edge:
//   - wb_regwrite_out <= mem_regwrite_in;
//   - wb_regwraddr_out <= mem_regwraddr_in;
//   - wb_regwrdata_out <= memtoreg ? dmem_rdata : bustoreg ? bus data : mem_alu_in.
// - While mem_stall=1: wb_regwrite_out <= 0 (bubble). Other wb_* fields hold.
// - Stores: wb_regwrite_out follows mem_regwrite_in (decoder drives 0); no dmem read data captured.
// - Latency is 1 cycle EX/MEM->MEM/WB plus memory/bus wait cycles.
// - dmem_ack and bus_valid are ignored when no matching request is outstanding.
// TESTING
// - ADD: regwrite=1, alu_in=16'h1234, rd=5, no mem op -> next cycle wb_regwrite=1, rd=5, data=16'h1234; mem_stall stays 0.
// - Load, ack same cycle, rdata=16'hBEEF, addr 16'h0040, rd=3 -> dmem_req 1 cycle, no stall; next cycle wb data=16'hBEEF.
// - Load, ack on 3rd cycle -> mem_stall=1 for 2 cycles, wb_regwrite=0 during stall, then wb data=rdata; dmem_addr stable throughout.
// - Store addr 16'h0010, wrdata=16'h00AA, ack after 1 wait -> dmem_we=1, wdata=16'h00AA, 1 stall cycle, wb_regwrite=0.
// - Bus read, no bus_valid, BUS_TO=4 -> stall until count=4, then wb data=16'h0000 and bus_err=1, held until reset.
// - rst_n low during MEM_WAIT -> dmem_req=0 and mem_stall=0 at once; after release the FSM is IDLE and all wb_*=0.

Source files
------------

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - CPU memory stage: data-memory and accelerator-bus access, stall, MEM/WB register
module mem_stage #(
  parameter int ADDR_W = 16,
  parameter int BUS_TO = 255,
  parameter int TO_W   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_regwrite_in,
  input  logic              mem_memtoreg_in,
  input  logic              mem_bustoreg_in,
  input  logic              mem_memread_in,
  input  logic              mem_memwrite_in,
  input  logic [15:0]       mem_alu_in,
  input  logic [15:0]       mem_wrdata_in,
  input  logic [3:0]        mem_regwraddr_in,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [15:0]       dmem_wdata,
  input  logic [15:0]       dmem_rdata,
  input  logic              dmem_ack,
  output logic              bus_req,
  output logic [15:0]       bus_addr,
  input  logic [15:0]       bus_rdata,
  input  logic              bus_valid,
  output logic              mem_stall,
  output logic              fwd_regwrite,
  output logic              fwd_memread,
  output logic [3:0]        fwd_regwraddr,
  output logic [15:0]       fwd_regwrdata,
  output logic              wb_regwrite_out,
  output logic [3:0]        wb_regwraddr_out,
  output logic [15:0]       wb_regwrdata_out,
  output logic              bus_err
);

  typedef enum logic [1:0] {S_IDLE, S_MEM_WAIT, S_BUS_WAIT} state_t;

  state_t          state;
  logic [TO_W-1:0] to_cnt;
  logic            mem_op;
  logic            bus_op;
  logic            bus_timeout;
  logic [15:0]     bus_data;
  logic [15:0]     wb_data_nxt;

  // A memory op wins over a bus read carried by the same instruction.
  assign mem_op = mem_memread_in | mem_memwrite_in;
  assign bus_op = mem_bustoreg_in & ~mem_op;

  // Requests are gated by rst_n so they drop the instant reset asserts.
  assign dmem_req = rst_n & (((state == S_IDLE) & mem_op) | (state == S_MEM_WAIT));
  assign bus_req  = rst_n & (((state == S_IDLE) & bus_op) | (state == S_BUS_WAIT));

  assign dmem_we    = mem_memwrite_in;
  assign dmem_addr  = mem_alu_in[ADDR_W-1:0];
  assign dmem_wdata = mem_wrdata_in;
  assign bus_addr   = mem_alu_in;

  assign bus_timeout = (state == S_BUS_WAIT) & (to_cnt == TO_W'(BUS_TO)) & ~bus_valid;

  assign mem_stall = (dmem_req & ~dmem_ack) | (bus_req & ~bus_valid & ~bus_timeout);

  assign fwd_regwrite  = mem_regwrite_in;
  assign fwd_memread   = mem_memread_in | mem_bustoreg_in;
  assign fwd_regwraddr = mem_regwraddr_in;
  assign fwd_regwrdata = mem_alu_in;

  // A timed-out bus read returns zero.
  assign bus_data    = bus_valid ? bus_rdata : 16'h0000;
  assign wb_data_nxt = mem_memtoreg_in ? dmem_rdata :
                       bus_op          ? bus_data   : mem_alu_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= S_IDLE;
      to_cnt           <= '0;
      bus_err          <= 1'b0;
      wb_regwrite_out  <= 1'b0;
      wb_regwraddr_out <= 4'd0;
      wb_regwrdata_out <= 16'h0000;
    end else begin
      case (state)
        S_IDLE: begin
          if (mem_op && !dmem_ack) begin
            state <= S_MEM_WAIT;
          end else if (bus_op && !bus_valid) begin
            state  <= S_BUS_WAIT;
            to_cnt <= '0;
          end
        end
        S_MEM_WAIT: begin
          if (dmem_ack) state <= S_IDLE;
        end
        S_BUS_WAIT: begin
          to_cnt <= to_cnt + 1'b1;
          if (bus_valid || bus_timeout) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase

      if (bus_timeout) bus_err <= 1'b1;

      if (mem_stall) begin
        wb_regwrite_out <= 1'b0;
      end else begin
        wb_regwrite_out  <= mem_regwrite_in;
        wb_regwraddr_out <= mem_regwraddr_in;
        wb_regwrdata_out <= wb_data_nxt;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - scoreboard bench for mem_stage with random instruction mix and reference model
module tb_mem_stage;
  localparam int ADDR_W = 16;
  localparam int BUS_TO = 4;
  localparam int TO_W   = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic mem_regwrite_in, mem_memtoreg_in, mem_bustoreg_in, mem_memread_in, mem_memwrite_in;
  logic [15:0] mem_alu_in, mem_wrdata_in;
  logic [3:0]  mem_regwraddr_in;
  logic dmem_req, dmem_we, dmem_ack, bus_req, bus_valid, mem_stall;
  logic [ADDR_W-1:0] dmem_addr;
  logic [15:0] dmem_wdata, dmem_rdata, bus_addr, bus_rdata;
  logic fwd_regwrite, fwd_memread, wb_regwrite_out, bus_err;
  logic [3:0]  fwd_regwraddr, wb_regwraddr_out;
  logic [15:0] fwd_regwrdata, wb_regwrdata_out;

  mem_stage #(.ADDR_W(ADDR_W), .BUS_TO(BUS_TO), .TO_W(TO_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_regwrite_in(mem_regwrite_in), .mem_memtoreg_in(mem_memtoreg_in),
    .mem_bustoreg_in(mem_bustoreg_in), .mem_memread_in(mem_memread_in),
    .mem_memwrite_in(mem_memwrite_in), .mem_alu_in(mem_alu_in),
    .mem_wrdata_in(mem_wrdata_in), .mem_regwraddr_in(mem_regwraddr_in),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .bus_req(bus_req), .bus_addr(bus_addr), .bus_rdata(bus_rdata), .bus_valid(bus_valid),
    .mem_stall(mem_stall), .fwd_regwrite(fwd_regwrite), .fwd_memread(fwd_memread),
    .fwd_regwraddr(fwd_regwraddr), .fwd_regwrdata(fwd_regwrdata),
    .wb_regwrite_out(wb_regwrite_out), .wb_regwraddr_out(wb_regwraddr_out),
    .wb_regwrdata_out(wb_regwrdata_out), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rw;
    logic [3:0]  rd;
    logic [15:0] data;
  } wb_t;

  wb_t sb[$];
  int  checks = 0;
  int  failures = 0;
  bit  err_model = 1'b0;
  bit  done = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Monitor: each non-stalled cycle retires one instruction into MEM/WB.
  bit  have_prev = 1'b0;
  bit  prev_stall = 1'b0;
  wb_t mon_e;
  always @(negedge clk) begin
    if (!rst_n || done) begin
      have_prev = 1'b0;
    end else begin
      if (have_prev) begin
        if (!prev_stall) begin
          if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL sb_empty actual=retire required=none t=%0t", $time);
          end else begin
            mon_e = sb.pop_front();
            chk("wb_regwrite", wb_regwrite_out, mon_e.rw);
            chk("wb_regwraddr", wb_regwraddr_out, mon_e.rd);
            chk("wb_regwrdata", wb_regwrdata_out, mon_e.data);
          end
        end else begin
          chk("wb_bubble", wb_regwrite_out, 1'b0);
        end
      end
      prev_stall = mem_stall;
      have_prev  = 1'b1;
    end
  end

  // Called at posedge+1; returns at posedge+1 after the completion edge.
  // d = cycle (0-based) on which ack/valid arrives.
  task automatic issue(input logic rw, input logic mt, input logic bt, input logic mr, input logic mw,
                       input logic [15:0] alu, input logic [15:0] wd, input logic [3:0] rd,
                       input int d, input logic [15:0] rdat);
    logic memop, busop, to;
    int   comp;
    wb_t  e;
    memop = mr | mw;
    busop = bt & ~memop;
    to    = busop && (d > BUS_TO + 1);
    comp  = memop ? d : (busop ? (to ? BUS_TO + 1 : d) : 0);
    e.rw  = rw;
    e.rd  = rd;
    if (mt)         e.data = rdat;
    else if (busop) e.data = to ? 16'h0000 : rdat;
    else            e.data = alu;
    sb.push_back(e);
    mem_regwrite_in  = rw;
    mem_memtoreg_in  = mt;
    mem_bustoreg_in  = bt;
    mem_memread_in   = mr;
    mem_memwrite_in  = mw;
    mem_alu_in       = alu;
    mem_wrdata_in    = wd;
    mem_regwraddr_in = rd;
    for (int cyc = 0; cyc <= comp; cyc++) begin
      if (cyc > 0) begin
        @(posedge clk);
        #1;
      end
      dmem_ack   = memop ? (cyc == d) : 1'($urandom);
      dmem_rdata = (memop && cyc == d) ? rdat : 16'($urandom);
      bus_valid  = busop ? (cyc == d) : 1'($urandom);
      bus_rdata  = (busop && cyc == d) ? rdat : 16'($urandom);
      @(negedge clk);
      chk("mem_stall", mem_stall, cyc != comp);
      chk("dmem_req", dmem_req, memop);
      if (memop) begin
        chk("dmem_we", dmem_we, mw);
        chk("dmem_addr", dmem_addr, alu);
        chk("dmem_wdata", dmem_wdata, wd);
      end
      chk("bus_req", bus_req, busop);
      if (busop) chk("bus_addr", bus_addr, alu);
      chk("fwd_regwrite", fwd_regwrite, rw);
      chk("fwd_memread", fwd_memread, mr | bt);
      chk("fwd_regwraddr", fwd_regwraddr, rd);
      chk("fwd_regwrdata", fwd_regwrdata, alu);
      chk("bus_err", bus_err, err_model);
    end
    if (to) err_model = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic rand_instr();
    int k;
    k = $urandom_range(0, 4);
    case (k)
      0: issue(1, 0, 0, 0, 0, 16'($urandom), 16'($urandom), 4'($urandom), 0, 16'($urandom));
      1: issue(1, 1, 1'($urandom), 1, 0, 16'($urandom), 16'($urandom), 4'($urandom),
               $urandom_range(0, 3), 16'($urandom));
      2: issue(0, 0, 0, 0, 1, 16'($urandom), 16'($urandom), 4'($urandom),
               $urandom_range(0, 3), 16'($urandom));
      3: issue(1, 0, 1, 0, 0, 16'($urandom), 16'($urandom), 4'($urandom),
               $urandom_range(0, 7), 16'($urandom));
      default: issue(0, 0, 0, 0, 0, 16'($urandom), 16'($urandom), 4'($urandom), 0, 16'($urandom));
    endcase
  endtask

  task automatic chk_wb_zero(input string tag);
    chk({tag, "_wb_regwrite"}, wb_regwrite_out, 1'b0);
    chk({tag, "_wb_regwraddr"}, wb_regwraddr_out, 4'd0);
    chk({tag, "_wb_regwrdata"}, wb_regwrdata_out, 16'h0000);
    chk({tag, "_bus_err"}, bus_err, 1'b0);
  endtask

  // A load that never gets acked, interrupted by reset; returns at posedge+1 with rst_n released.
  task automatic reset_mid_wait();
    mem_regwrite_in  = 1'b1;
    mem_memtoreg_in  = 1'b1;
    mem_bustoreg_in  = 1'b0;
    mem_memread_in   = 1'b1;
    mem_memwrite_in  = 1'b0;
    mem_alu_in       = 16'h0123;
    mem_regwraddr_in = 4'd7;
    dmem_ack         = 1'b0;
    bus_valid        = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("wait_stall", mem_stall, 1'b1);
      chk("wait_dmem_req", dmem_req, 1'b1);
      chk("wait_addr", dmem_addr, 16'h0123);
    end
    #1 rst_n = 1'b0;
    #1;
    chk("rst_dmem_req", dmem_req, 1'b0);
    chk("rst_mem_stall", mem_stall, 1'b0);
    chk_wb_zero("rst_async");
    sb.delete();
    err_model = 1'b0;
    @(negedge clk);
    chk_wb_zero("rst_hold");
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    mem_regwrite_in = 0; mem_memtoreg_in = 0; mem_bustoreg_in = 0;
    mem_memread_in = 0; mem_memwrite_in = 0; mem_alu_in = 0;
    mem_wrdata_in = 0; mem_regwraddr_in = 0;
    dmem_rdata = 0; dmem_ack = 0; bus_rdata = 0; bus_valid = 0;
    repeat (3) @(posedge clk);
    #1;
    chk_wb_zero("reset");
    chk("reset_dmem_req", dmem_req, 1'b0);
    chk("reset_bus_req", bus_req, 1'b0);
    chk("reset_stall", mem_stall, 1'b0);
    rst_n = 1'b1;

    issue(1, 0, 0, 0, 0, 16'h1234, 16'h0000, 4'd5, 0, 16'h0000);  // ADD
    issue(1, 1, 0, 1, 0, 16'h0040, 16'h0000, 4'd3, 0, 16'hBEEF);  // load, zero-wait
    issue(1, 1, 0, 1, 0, 16'h0080, 16'h0000, 4'd9, 2, 16'hCAFE);  // load, ack on 3rd cycle
    issue(0, 0, 0, 0, 1, 16'h0010, 16'h00AA, 4'd0, 1, 16'h0000);  // store, 1 wait
    issue(1, 0, 1, 0, 0, 16'h8000, 16'h0000, 4'd2, 2, 16'h5A5A);  // bus read, 2 waits
    issue(1, 0, 1, 0, 0, 16'h8002, 16'h0000, 4'd4, BUS_TO + 1, 16'h3C3C);  // valid on deadline
    issue(1, 0, 1, 0, 0, 16'h8004, 16'h0000, 4'd6, 100, 16'h7777);  // timeout
    issue(1, 1, 1, 1, 0, 16'h0044, 16'h0000, 4'd8, 1, 16'h1111);  // load beats bustoreg
    issue(1, 0, 0, 0, 0, 16'h4321, 16'h0000, 4'd1, 0, 16'h0000);

    for (int i = 0; i < 300; i++) rand_instr();

    reset_mid_wait();
    issue(1, 0, 0, 0, 0, 16'h0F0F, 16'h0000, 4'd12, 0, 16'h0000);
    for (int i = 0; i < 30; i++) rand_instr();

    @(negedge clk);
    #1;
    done = 1'b1;
    chk("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
